// File: rtl/ibex_regfile_ctx_seq_if.sv
// Bundles the command, status, register-file and stream ports of the context sequencer.
// master is the sequencer's view; slave is the view of the surrounding regfile/controller.
interface ibex_regfile_ctx_seq_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic                 cmd_restore_i;
  logic                 abort_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic [AddrWidth-1:0] rf_raddr_o;
  logic [DataWidth-1:0] rf_rdata_i;
  logic [AddrWidth-1:0] rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;
  logic                 sv_valid_o;
  logic [DataWidth-1:0] sv_data_o;
  logic                 sv_last_o;
  logic                 sv_ready_i;
  logic                 rs_valid_i;
  logic [DataWidth-1:0] rs_data_i;
  logic                 rs_last_i;
  logic                 rs_ready_o;

  modport master (
    input  cmd_valid_i, cmd_restore_i, abort_i, rf_rdata_i, sv_ready_i,
           rs_valid_i, rs_data_i, rs_last_i,
    output cmd_ready_o, busy_o, done_o, err_o, rf_raddr_o, rf_waddr_o,
           rf_wdata_o, rf_we_o, sv_valid_o, sv_data_o, sv_last_o, rs_ready_o
  );

  modport slave (
    output cmd_valid_i, cmd_restore_i, abort_i, rf_rdata_i, sv_ready_i,
           rs_valid_i, rs_data_i, rs_last_i,
    input  cmd_ready_o, busy_o, done_o, err_o, rf_raddr_o, rf_waddr_o,
           rf_wdata_o, rf_we_o, sv_valid_o, sv_data_o, sv_last_o, rs_ready_o
  );
endinterface

// File: rtl/ibex_regfile_ctx_seq.sv
// Context save/restore sequencer: streams GPRs x1..xNR-1 out of the register file,
// or writes a received stream back into it, while the core is halted.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready_o high
// SAVE    | reading x[idx] and presenting it on the save stream
// RESTORE | writing each accepted restore word to x[idx]
// DONE    | one-cycle done_o pulse, then back to IDLE
module ibex_regfile_ctx_seq #(
  parameter bit RV32E     = 1'b0,
  parameter int DataWidth = 32,
  parameter int NumRegs   = 32,
  parameter int AddrWidth = $clog2(NumRegs)
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  ibex_regfile_ctx_seq_if.master bus
);

  localparam int NR = RV32E ? 16 : NumRegs;
  localparam logic [AddrWidth-1:0] FirstIdx = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] LastIdx  = AddrWidth'(NR - 1);

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= FirstIdx;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    err_d           = 1'b0;
    bus.cmd_ready_o = 1'b0;
    bus.busy_o      = 1'b0;
    bus.done_o      = 1'b0;
    bus.err_o       = err_q;
    bus.rf_raddr_o  = '0;
    bus.rf_waddr_o  = '0;
    bus.rf_wdata_o  = '0;
    bus.rf_we_o     = 1'b0;
    bus.sv_valid_o  = 1'b0;
    bus.sv_data_o   = '0;
    bus.sv_last_o   = 1'b0;
    bus.rs_ready_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.cmd_ready_o = 1'b1;
        if (bus.cmd_valid_i) begin
          state_d = bus.cmd_restore_i ? RESTORE : SAVE;
          idx_d   = FirstIdx;
        end
      end

      SAVE: begin
        bus.busy_o     = 1'b1;
        bus.rf_raddr_o = idx_q;
        bus.sv_data_o  = bus.rf_rdata_i;
        bus.sv_last_o  = (idx_q == LastIdx);
        // Valid is withdrawn during abort so the word is visibly not consumed.
        bus.sv_valid_o = !bus.abort_i;
        if (bus.abort_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
          idx_d   = FirstIdx;
        end else if (bus.sv_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = DONE;
            idx_d   = FirstIdx;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      RESTORE: begin
        bus.busy_o     = 1'b1;
        bus.rs_ready_o = !bus.abort_i;
        if (bus.abort_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
          idx_d   = FirstIdx;
        end else if (bus.rs_valid_i) begin
          bus.rf_we_o    = 1'b1;
          bus.rf_waddr_o = idx_q;
          bus.rf_wdata_o = bus.rs_data_i;
          if (idx_q == LastIdx) begin
            state_d = bus.rs_last_i ? DONE : IDLE;
            err_d   = !bus.rs_last_i;
            idx_d   = FirstIdx;
          end else if (bus.rs_last_i) begin
            // Sender ended the stream early: the word is kept, the context is not.
            state_d = IDLE;
            err_d   = 1'b1;
            idx_d   = FirstIdx;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      DONE: begin
        bus.done_o = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
        idx_d   = FirstIdx;
      end
    endcase
  end

endmodule

// File: tb/tb_ibex_regfile_ctx_seq.sv
// Directed bench for the context sequencer: behavioural register files, expected
// stream/write queues, and immediate-assertion checks on every observed beat.
module tb_ibex_regfile_ctx_seq;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  ibex_regfile_ctx_seq_if #(.DataWidth(32), .AddrWidth(5)) bus ();
  ibex_regfile_ctx_seq_if #(.DataWidth(32), .AddrWidth(5)) bus_e ();

  ibex_regfile_ctx_seq #(.RV32E(1'b0), .DataWidth(32), .NumRegs(32)) u_dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  ibex_regfile_ctx_seq #(.RV32E(1'b1), .DataWidth(32), .NumRegs(32)) u_dut_e (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus_e)
  );

  logic [31:0] rf   [32];
  logic [31:0] rf_e [32];
  assign bus.rf_rdata_i   = rf[bus.rf_raddr_o];
  assign bus_e.rf_rdata_i = rf_e[bus_e.rf_raddr_o];

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [36:0] wr_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; register-file writes seen before the edge land at the edge.
  task automatic tick();
    logic w, w2;
    logic [4:0] a, a2;
    logic [31:0] d, d2;
    w  = bus.rf_we_o;   a  = bus.rf_waddr_o;   d  = bus.rf_wdata_o;
    w2 = bus_e.rf_we_o; a2 = bus_e.rf_waddr_o; d2 = bus_e.rf_wdata_o;
    @(posedge clk_i);
    if (w)  rf[a]    = d;
    if (w2) rf_e[a2] = d2;
    #2;
  endtask

  task automatic preload();
    for (int k = 0; k < 32; k++) begin
      rf[k]   = (k == 0) ? 32'h0 : 32'h1000 + k;
      rf_e[k] = (k == 0) ? 32'h0 : 32'h2000 + k;
    end
  endtask

  task automatic run_save(input bit toggle);
    int cyc, beats, done_at, we_hits;
    logic held;
    logic [31:0] hd, e;
    logic [4:0] ha;
    exp_q.delete();
    for (int k = 1; k < 32; k++) exp_q.push_back(32'h1000 + k);
    bus.cmd_restore_i = 1'b0;
    bus.cmd_valid_i   = 1'b1;
    #1;
    chk("save_cmd_ready", bus.cmd_ready_o, 1);
    tick();
    bus.cmd_valid_i = 1'b0;
    cyc = 1; beats = 0; done_at = 0; we_hits = 0; held = 1'b0;
    while (done_at == 0 && cyc < 200) begin
      bus.sv_ready_i = toggle ? ((cyc % 3) == 1) : 1'b1;
      #1;
      if (bus.rf_we_o) we_hits++;
      if (held) begin
        chk("save_hold_data", bus.sv_data_o, hd);
        chk("save_hold_addr", bus.rf_raddr_o, ha);
      end
      held = 1'b0;
      if (bus.sv_valid_o && !bus.sv_ready_i) begin
        held = 1'b1; hd = bus.sv_data_o; ha = bus.rf_raddr_o;
      end
      if (bus.sv_valid_o && bus.sv_ready_i) begin
        chk("save_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("save_data", bus.sv_data_o, e);
          chk("save_last", bus.sv_last_o, e == 32'h101F);
        end
        beats++;
      end
      if (bus.done_o) done_at = cyc;
      tick();
      cyc++;
    end
    bus.sv_ready_i = 1'b0;
    #1;
    chk("save_beats", beats, 31);
    chk("save_done_cycle", done_at, toggle ? 92 : 32);
    chk("save_we_never", we_hits, 0);
    chk("save_q_left", exp_q.size(), 0);
    chk("save_idle_ready", bus.cmd_ready_o, 1);
  endtask

  task automatic run_restore(input int last_at);
    int k, n_done, n_err, bad;
    logic valid;
    logic [36:0] w;
    logic [31:0] ex;
    preload();
    wr_q.delete();
    bus.cmd_restore_i = 1'b1;
    bus.cmd_valid_i   = 1'b1;
    #1;
    chk("rs_cmd_ready", bus.cmd_ready_o, 1);
    tick();
    bus.cmd_valid_i = 1'b0;
    k = 1; n_done = 0; n_err = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      valid = (k <= last_at) && ((cyc % 4) != 3);
      bus.rs_valid_i = valid;
      bus.rs_data_i  = 32'hA5A50000 + k;
      bus.rs_last_i  = (k == last_at);
      if (valid) wr_q.push_back({5'(k), 32'hA5A50000 + 32'(k)});
      #1;
      if (valid) chk("rs_ready", bus.rs_ready_o, 1);
      if (bus.rf_we_o) begin
        chk("rs_wq_nonempty", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("rs_waddr", bus.rf_waddr_o, w[36:32]);
          chk("rs_wdata", bus.rf_wdata_o, w[31:0]);
        end
      end
      if (bus.done_o) n_done++;
      if (bus.err_o) n_err++;
      tick();
      if (valid) k++;
    end
    bus.rs_valid_i = 1'b0;
    bus.rs_last_i  = 1'b0;
    #1;
    chk("rs_wq_left", wr_q.size(), 0);
    chk("rs_done_count", n_done, (last_at == 31) ? 1 : 0);
    chk("rs_err_count", n_err, (last_at == 31) ? 0 : 1);
    bad = 0;
    for (int r = 1; r < 32; r++) begin
      ex = (r <= last_at) ? 32'hA5A50000 + r : 32'h1000 + r;
      if (rf[r] !== ex) bad++;
    end
    chk("rs_rf_contents_bad", bad, 0);
    chk("rs_x0_untouched", rf[0], 0);
    chk("rs_idle_ready", bus.cmd_ready_o, 1);
    chk("rs_idle_busy", bus.busy_o, 0);
  endtask

  initial begin
    int beats, done_at;
    logic [31:0] e;
    bus.cmd_valid_i = 0; bus.cmd_restore_i = 0; bus.abort_i = 0; bus.sv_ready_i = 0;
    bus.rs_valid_i = 0; bus.rs_data_i = 0; bus.rs_last_i = 0;
    bus_e.cmd_valid_i = 0; bus_e.cmd_restore_i = 0; bus_e.abort_i = 0; bus_e.sv_ready_i = 0;
    bus_e.rs_valid_i = 0; bus_e.rs_data_i = 0; bus_e.rs_last_i = 0;
    preload();
    #1 rst_ni = 1'b0;
    #5;
    chk("rst_cmd_ready", bus.cmd_ready_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_sv_valid", bus.sv_valid_o, 0);
    chk("rst_we", bus.rf_we_o, 0);
    chk("rst_raddr", bus.rf_raddr_o, 0);
    chk("rst_rs_ready", bus.rs_ready_o, 0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // abort in IDLE must be ignored
    bus.abort_i = 1'b1;
    #1;
    tick();
    bus.abort_i = 1'b0;
    #1;
    chk("idle_abort_err", bus.err_o, 0);
    chk("idle_abort_ready", bus.cmd_ready_o, 1);

    run_save(1'b0);
    tick();
    run_save(1'b1);
    tick();
    run_restore(31);
    tick();
    run_restore(10);
    tick();

    // abort on the fifth save beat
    preload();
    exp_q.delete();
    for (int k = 1; k < 5; k++) exp_q.push_back(32'h1000 + k);
    bus.cmd_restore_i = 1'b0;
    bus.cmd_valid_i   = 1'b1;
    bus.sv_ready_i    = 1'b1;
    #1;
    tick();
    bus.cmd_valid_i = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      #1;
      chk("ab_valid", bus.sv_valid_o, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ab_data", bus.sv_data_o, e);
      end
      tick();
    end
    bus.abort_i = 1'b1;
    #1;
    chk("ab_raddr5", bus.rf_raddr_o, 5);
    chk("ab_busy", bus.busy_o, 1);
    tick();
    bus.abort_i    = 1'b0;
    bus.sv_ready_i = 1'b0;
    #1;
    chk("ab_err", bus.err_o, 1);
    chk("ab_busy_after", bus.busy_o, 0);
    chk("ab_cmd_ready", bus.cmd_ready_o, 1);
    chk("ab_done", bus.done_o, 0);
    tick();
    #1;
    chk("ab_err_pulse", bus.err_o, 0);
    run_save(1'b0);
    tick();

    // RV32E instance: 15-beat save
    exp_q.delete();
    for (int k = 1; k < 16; k++) exp_q.push_back(32'h2000 + k);
    bus_e.cmd_restore_i = 1'b0;
    bus_e.cmd_valid_i   = 1'b1;
    bus_e.sv_ready_i    = 1'b1;
    #1;
    tick();
    bus_e.cmd_valid_i = 1'b0;
    beats = 0; done_at = 0;
    for (int cyc = 1; cyc < 40 && done_at == 0; cyc++) begin
      #1;
      if (bus_e.sv_valid_o) begin
        chk("e_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("e_data", bus_e.sv_data_o, e);
          chk("e_last", bus_e.sv_last_o, e == 32'h200F);
        end
        beats++;
      end
      if (bus_e.done_o) done_at = cyc;
      tick();
    end
    bus_e.sv_ready_i = 1'b0;
    chk("e_beats", beats, 15);
    chk("e_done_cycle", done_at, 16);
    tick();

    // RV32E instance: reset pulled mid-restore
    bus_e.cmd_restore_i = 1'b1;
    bus_e.cmd_valid_i   = 1'b1;
    #1;
    tick();
    bus_e.cmd_valid_i = 1'b0;
    bus_e.rs_valid_i  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus_e.rs_data_i = 32'hC0DE0000 + k;
      #1;
      if (k < 3) tick();
    end
    chk("er_we_before", bus_e.rf_we_o, 1);
    chk("er_busy_before", bus_e.busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("er_we_async", bus_e.rf_we_o, 0);
    chk("er_busy_async", bus_e.busy_o, 0);
    chk("er_ready_async", bus_e.cmd_ready_o, 1);
    chk("er_rs_ready_async", bus_e.rs_ready_o, 0);
    bus_e.rs_valid_i = 1'b0;
    tick();
    #1;
    chk("er_err_none", bus_e.err_o, 0);
    chk("er_done_none", bus_e.done_o, 0);
    chk("er_x3_kept", rf_e[3], 32'h2003);
    rst_ni = 1'b1;
    tick();
    #1;
    chk("er_idle_after", bus_e.cmd_ready_o, 1);
    chk("er_err_after", bus_e.err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
